// File: rtl/imem_boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_pkg
//  Brief    : Shared state encoding and address constants for imem_boot_ctrl.
//  Revision : 1.0
// ============================================================================
package imem_boot_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } boot_state_e;

  localparam int unsigned WORD_SHIFT = 2;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : imem_boot_pkg
`default_nettype wire

// File: rtl/imem_boot_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_if
//  Brief    : Loader word stream (valid/ready) between program source and
//             the boot controller.
//  Revision : 1.0
// ============================================================================
interface imem_boot_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  LdValid;
  logic [DATA_WIDTH-1:0] LdData;
  logic                  LdLast;
  logic                  LdReady;

  modport master (
    output LdValid,
    output LdData,
    output LdLast,
    input  LdReady
  );

  modport slave (
    input  LdValid,
    input  LdData,
    input  LdLast,
    output LdReady
  );

endinterface : imem_boot_if
`default_nettype wire

// File: rtl/imem_boot_checksum.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_checksum
//  Brief    : XOR accumulator over accepted loader words; used only when
//             IMEM_BOOT_CHECKSUM_EN is defined.
//  Revision : 1.0
// ============================================================================
module imem_boot_checksum #(
  parameter int WIDTH = 32
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  input  wire logic [WIDTH-1:0] din_i,
  output logic      [WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ din_i;
    end
  end

  assign acc_o = acc_q;

endmodule : imem_boot_checksum
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_ctrl
//  Brief    : Loads a program into instruction memory, then clears the PC and
//             releases fetch. Optional checksum via IMEM_BOOT_CHECKSUM_EN.
//  Revision : 1.0
// ============================================================================
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 100
) (
  input  wire logic                  CLK,
  input  wire logic                  RST,
  imem_boot_if.slave                 ld,
  input  wire logic                  BootReq,
  input  wire logic                  FetchStallReq,
  output logic                       PCEnF,
  output logic                       PCResetF,
  output logic                       IMemWE,
  output logic      [ADDR_WIDTH-1:0] IMemWA,
  output logic      [DATA_WIDTH-1:0] IMemWD,
  output logic                       BootDone,
`ifdef IMEM_BOOT_CHECKSUM_EN
  input  wire logic [DATA_WIDTH-1:0] ExpChecksum,
  output logic      [DATA_WIDTH-1:0] LdChecksum,
`endif
  output logic                       LdError
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  boot_state_e           state_q;
  logic [CNT_W-1:0]      wcnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [DATA_WIDTH-1:0] wd_q;

  logic                  ld_ready_w;
  logic                  take_w;
  logic                  full_w;
  logic                  write_w;
  logic                  overflow_w;
  logic                  sum_ok_w;
  logic [ADDR_WIDTH-1:0] wa_d;

  assign ld_ready_w = (state_q == ST_LOAD) && !BootReq;
  assign take_w     = ld.LdValid && ld_ready_w;
  assign full_w     = (wcnt_q == CNT_FULL);
  assign write_w    = take_w && !full_w;
  assign overflow_w = take_w && full_w;
  assign wa_d       = ADDR_WIDTH'(wcnt_q) << WORD_SHIFT;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_w;

  // BootReq is the only way into LOAD after reset, so it doubles as the clear.
  imem_boot_checksum #(
    .WIDTH (DATA_WIDTH)
  ) u_checksum (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (BootReq),
    .en_i  (write_w),
    .din_i (ld.LdData),
    .acc_o (cks_w)
  );

  assign sum_ok_w   = ((cks_w ^ ld.LdData) == ExpChecksum);
  assign LdChecksum = cks_w;
`else
  assign sum_ok_w   = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      we_q <= write_w;
      if (write_w) begin
        wa_q <= wa_d;
        wd_q <= ld.LdData;
      end

      if (BootReq) begin
        state_q <= ST_LOAD;
        wcnt_q  <= '0;
      end else begin
        unique case (state_q)
          ST_LOAD: begin
            if (overflow_w) begin
              state_q <= ST_ERROR;
            end else if (write_w) begin
              wcnt_q <= wcnt_q + 1'b1;
              // A failed checksum still lets the last word land in memory.
              if (ld.LdLast) begin
                state_q <= sum_ok_w ? ST_FLUSH : ST_ERROR;
              end
            end
          end
          ST_FLUSH: state_q <= ST_RUN;
          ST_RUN:   state_q <= ST_RUN;
          ST_ERROR: state_q <= ST_ERROR;
          default:  state_q <= ST_LOAD;
        endcase
      end
    end
  end

  assign ld.LdReady = ld_ready_w;
  assign PCResetF   = (state_q == ST_FLUSH);
  assign PCEnF      = (state_q == ST_FLUSH) || ((state_q == ST_RUN) && !FetchStallReq);
  assign BootDone   = (state_q == ST_RUN);
  assign LdError    = (state_q == ST_ERROR);
  assign IMemWE     = we_q;
  assign IMemWA     = wa_q;
  assign IMemWD     = wd_q;

endmodule : imem_boot_ctrl
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_ctrl
//  Brief    : Directed and random stimulus against a program-level model of
//             the boot controller.
//  Revision : 1.0
// ============================================================================
module tb_imem_boot_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          BootReq = 1'b0;
  logic          FetchStallReq = 1'b0;
  logic          PCEnF, PCResetF, IMemWE, BootDone, LdError;
  logic [AW-1:0] IMemWA;
  logic [DW-1:0] IMemWD;
  logic [DW-1:0] exp_sum = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DW-1:0] ExpChecksum = '0;
  logic [DW-1:0] LdChecksum;
`endif

  imem_boot_if #(.DATA_WIDTH(DW)) ld ();

  always #5 CLK = ~CLK;

  imem_boot_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ld            (ld.slave),
    .BootReq       (BootReq),
    .FetchStallReq (FetchStallReq),
    .PCEnF         (PCEnF),
    .PCResetF      (PCResetF),
    .IMemWE        (IMemWE),
    .IMemWA        (IMemWA),
    .IMemWD        (IMemWD),
    .BootDone      (BootDone),
`ifdef IMEM_BOOT_CHECKSUM_EN
    .ExpChecksum   (ExpChecksum),
    .LdChecksum    (LdChecksum),
`endif
    .LdError       (LdError)
  );

  // Instruction memory as seen by fetch.
  logic [DW-1:0] imem [DEPTH];
  always @(posedge CLK) begin
    if (IMemWE && (IMemWA / 4) < DEPTH) imem[IMemWA / 4] <= IMemWD;
  end

  // Program-level model: phase of the boot sequence and the loaded program.
  typedef enum int {P_LOADING, P_FLUSHING, P_RUNNING, P_FAILED} phase_t;
  phase_t        m_phase = P_LOADING;
  int            m_cnt = 0;
  logic [DW-1:0] m_prog [DEPTH];
  logic [DW-1:0] m_xor = '0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  bit            m_verify = 1'b0;
  int            m_len = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check_val("rst_LdReady",  ld.LdReady, 1);
    check_val("rst_PCEnF",    PCEnF, 0);
    check_val("rst_PCResetF", PCResetF, 0);
    check_val("rst_IMemWE",   IMemWE, 0);
    check_val("rst_IMemWA",   IMemWA, 0);
    check_val("rst_IMemWD",   IMemWD, 0);
    check_val("rst_BootDone", BootDone, 0);
    check_val("rst_LdError",  LdError, 0);
  endtask

  task automatic model_reset();
    m_phase  = P_LOADING;
    m_cnt    = 0;
    m_xor    = '0;
    m_we     = 1'b0;
    m_verify = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic last,
                       input logic boot, input logic stall);
    logic [DW-1:0] nx;
    bit            ok;
    @(negedge CLK);
    ld.LdValid = v; ld.LdData = d; ld.LdLast = last;
    BootReq = boot; FetchStallReq = stall;
`ifdef IMEM_BOOT_CHECKSUM_EN
    ExpChecksum = exp_sum;
`endif
    #1;
    if (m_verify) begin
      for (int i = 0; i < m_len; i++) check_val("imem_content", imem[i], m_prog[i]);
      m_verify = 1'b0;
    end
    check_val("LdReady",  ld.LdReady, (m_phase == P_LOADING) && !boot);
    check_val("PCEnF",    PCEnF, (m_phase == P_FLUSHING) || (m_phase == P_RUNNING && !stall));
    check_val("PCResetF", PCResetF, m_phase == P_FLUSHING);
    check_val("BootDone", BootDone, m_phase == P_RUNNING);
    check_val("LdError",  LdError, m_phase == P_FAILED);
    check_val("IMemWE",   IMemWE, m_we);
    if (m_we) begin
      check_val("IMemWA", IMemWA, m_wa);
      check_val("IMemWD", IMemWD, m_wd);
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    check_val("LdChecksum", LdChecksum, m_xor);
`endif
    @(posedge CLK);
    m_we = 1'b0;
    if (boot) begin
      m_phase = P_LOADING;
      m_cnt   = 0;
      m_xor   = '0;
    end else if (m_phase == P_LOADING && v) begin
      if (m_cnt == DEPTH) begin
        m_phase = P_FAILED;
      end else begin
        m_we = 1'b1; m_wa = AW'(m_cnt) * 4; m_wd = d;
        m_prog[m_cnt] = d;
        m_cnt++;
        nx = m_xor ^ d;
`ifdef IMEM_BOOT_CHECKSUM_EN
        ok = (nx == exp_sum);
`else
        ok = 1'b1;
`endif
        m_xor = nx;
        if (last) m_phase = ok ? P_FLUSHING : P_FAILED;
      end
    end else if (m_phase == P_FLUSHING) begin
      m_phase  = P_RUNNING;
      m_verify = 1'b1;
      m_len    = m_cnt;
    end
  endtask

  // Called just after a rising edge; asserts reset asynchronously mid-cycle.
  task automatic async_reset();
    #2;
    ld.LdValid = 1'b0; BootReq = 1'b0;
    RST = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] d;
    ld.LdValid = 1'b0; ld.LdData = '0; ld.LdLast = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values();
    @(negedge CLK);
    RST = 1'b1;

    // Three-word program, then a two-cycle stall in RUN.
    exp_sum = 32'h0;
    cycle(1, 32'h11, 0, 0, 0);
    cycle(1, 32'h22, 0, 0, 0);
    cycle(1, 32'h33, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Overflow: five words without LdLast into a four-word memory.
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 32'hA0 + i, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'hBB, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // BootReq collides with a valid word in LOAD.
    cycle(1, 32'hAA, 0, 1, 0);
    exp_sum = 32'h55;
    cycle(1, 32'h55, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Async reset after two words, then reload from address 0.
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h01, 0, 0, 0);
    cycle(1, 32'h02, 0, 0, 0);
    async_reset();
    exp_sum = 32'h77;
    cycle(1, 32'h77, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Checksum pass then fail (both reach RUN when checksum is absent).
    cycle(0, 0, 0, 1, 0);
    exp_sum = 32'hFF;
    cycle(1, 32'hF0, 0, 0, 0);
    cycle(1, 32'h0F, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    exp_sum = 32'h00;
    cycle(1, 32'hF0, 0, 0, 0);
    cycle(1, 32'h0F, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check_val("imem_w0", imem[0], 32'hF0);
    check_val("imem_w1", imem[1], 32'h0F);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      d = $urandom;
      exp_sum = ($urandom_range(3) != 0) ? (m_xor ^ d) : $urandom;
      cycle($urandom_range(3) != 0, d, $urandom_range(2) == 0,
            $urandom_range(11) == 0, $urandom_range(1) == 1);
      if ($urandom_range(199) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_imem_boot_ctrl
`default_nettype wire

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/reload controller for the fetch stage. It sequences the instruction memory and program counter so that fetch starts only after a complete program has been written. After reset it holds the PC, accepts a stream of instruction words over a valid/ready handshake and writes them into instruction memory at consecutive word addresses. It then clears the PC to 0 for one cycle and releases fetch, forwarding hazard-unit stalls to the PC enable. A later `BootReq` re-enters loading at any time.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, instruction memory byte-address width
- `DATA_WIDTH`, 32, instruction word width
- `DEPTH`, 100, instruction memory capacity in words

Ports:
- `CLK`  in  1  system clock; all state updates on rising edge
- `RST`  in  1  reset, asynchronous assert, active-low
- `LdValid`  in  1  loader word valid
- `LdData`  in  DATA_WIDTH  loader word
- `LdLast`  in  1  marks final word of program; qualified by `LdValid`
- `LdReady`  out  1  controller accepts a word this cycle
- `BootReq`  in  1  single-cycle request to reload program
- `FetchStallReq`  in  1  hazard-unit stall request for fetch
- `PCEnF`  out  1  1 = PC register may load next value
- `PCResetF`  out  1  synchronous clear of PC to 0 at next edge
- `IMemWE`  out  1  instruction memory write enable
- `IMemWA`  out  ADDR_WIDTH  write byte address (word index × 4)
- `IMemWD`  out  DATA_WIDTH  write data
- `BootDone`  out  1  level; program loaded and fetch running
- `LdError`  out  1  level; load aborted (overflow or checksum)

## Operation
- States: `LOAD`, `FLUSH`, `RUN`, `ERROR`. Reset state is `LOAD`.
- Handshake: a word is accepted when `LdValid & LdReady`.
- `LdReady = (state==LOAD) & ~BootReq`. The result is combinational from state and `BootReq`.
- `LOAD`:
  - Each accepted word is written at index `wcnt`; `wcnt` then increments.
  - `wcnt` is `$clog2(DEPTH+1)` bits wide and is cleared on entry to `LOAD`.
  - An accepted word with `LdLast=1` moves the FSM to `FLUSH`.
  - `LdValid` with `wcnt==DEPTH` is an overflow: the word is not written and the FSM moves to `ERROR`.
- `FLUSH`: lasts exactly one cycle.
  - Drives `PCResetF=1` and `PCEnF=1`, so PC becomes 0.
  - Next state is `RUN`.
- `RUN`:
  - `PCEnF = ~FetchStallReq`.
  - `BootDone=1`.
  - `BootReq` moves the FSM to `LOAD`.
- `ERROR`:
  - `LdError=1`, `PCEnF=0`, `LdReady=0`.
  - Only `BootReq` exits, to `LOAD`.
- Outside `RUN` and `FLUSH`, `PCEnF=0` and `PCResetF=0`.
- `BootReq` priority:
  - In any state, `BootReq` moves the FSM to `LOAD` and clears `wcnt`.
  - In `LOAD`, no word is accepted in the `BootReq` cycle.
  - `BootReq` clears `LdError` on the same edge.
- An empty program is not possible, since `LdLast` always carries a word. The minimum program is 1 word.
- Async reset mid-load discards all progress: state `LOAD`, `wcnt=0`. Memory contents are not cleared.

## Timing
- Reset values of outputs:
  - `PCEnF=0`, `PCResetF=0`, `IMemWE=0`, `IMemWA=0`, `IMemWD=0`, `BootDone=0`, `LdError=0`.
  - `LdReady=1`, because state is `LOAD` and `BootReq=0`.
- `IMemWE/WA/WD` are registered: asserted for the single cycle after acceptance. Write latency is 1 cycle.
- A word accepted at edge N is written into memory at edge N+1.
- `LdLast` accepted at edge N:
  - `FLUSH` during cycle N..N+1, which carries the final memory write.
  - PC is 0 and `RUN` begins from edge N+1.
  - The first fetch reads address 0 with all words present.
- Back-to-back acceptance at one word per cycle is supported.
- `PCEnF` in `RUN` is combinational from `FetchStallReq`: zero-cycle stall response.

## Configuration
- `IMEM_BOOT_CHECKSUM_EN` defined:
  - Adds input `ExpChecksum` (DATA_WIDTH) and output `LdChecksum` (DATA_WIDTH).
  - `LdChecksum` is the running XOR of accepted words. It is cleared on entry to `LOAD` and resets to 0.
  - On `LdLast` acceptance, the final XOR (including the last word) is compared with `ExpChecksum`. Mismatch moves to `ERROR` instead of `FLUSH`; the last word is still written.
- `IMEM_BOOT_CHECKSUM_EN` undefined:
  - Ports and logic are absent.
  - `LdLast` acceptance always moves to `FLUSH`.

## Structure
- Shared package `imem_boot_pkg`:
  - State encoding `LOAD=2'd0`, `FLUSH=2'd1`, `RUN=2'd2`, `ERROR=2'd3`.
  - Word-to-byte shift constant 2.
- One sub-module, `imem_boot_checksum`: XOR accumulator with clear/enable, instantiated only under the macro.
- FSM, counter and write registers stay in the top module.

## Test plan
- After reset, 3 words 0x11,0x22,0x33 are sent, last flagged on 0x33:
  - Writes go to addresses 0,4,8.
  - One `PCResetF` pulse, then `BootDone=1`.
  - `PCEnF=1` with stall low.
- In `RUN`, `FetchStallReq=1` for 2 cycles -> `PCEnF=0` exactly those 2 cycles.
- `DEPTH=4`, 5 words with no `LdLast`:
  - 4 writes occur and the 5th is not written.
  - `LdError=1`, `LdReady=0`.
  - `BootReq` then returns to `LOAD` with `LdError=0`.
- `BootReq` in the same cycle as `LdValid` during `LOAD`:
  - The word is not accepted.
  - The next accepted word is written at address 0.
- Reset asserted after 2 words -> all outputs return to reset values immediately; a reload starts at address 0.
- With macro, words 0xF0,0x0F and `ExpChecksum=0xFF` -> `RUN`; with `ExpChecksum=0x00` -> `ERROR`, and both words are written.
